// File: rtl/led_pkg.sv
// Shared types and constants for the LED blink arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package led_pkg;

  // Service phases of the LED owner.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Board default: CLOCK_50 cycles per LED half-period.
  localparam int DEF_TICK_DIV = 5000;
  localparam int DEF_TICK_W   = $clog2(DEF_TICK_DIV);

  // Width of a counter that has to reach div-1.
  function automatic int tick_width(input int div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/led_blink_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, scanning upward with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to take the grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N < 2) ? 1 : $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] index
);

  int               cand_int;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk the requesters starting at ptr; the first hit wins.
  always_comb begin
    grant    = '0;
    index    = '0;
    found    = 1'b0;
    cand_int = 0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand_int = int'(ptr) + i;
      if (cand_int >= N) begin
        cand_int = cand_int - N;
      end
      cand = IDX_W'(cand_int);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/led_blink_arbiter.sv
// Shares one LED among N_REQ requesters; each owner gets a burst of k blinks plus an off gap.
// Latency: grant one edge after request; done (2k+1)*TICK_DIV cycles after grant (TICK_DIV for k=0).
// Backpressure: requests wait at level until served; no grant in the cycle done is high.
module led_blink_arbiter
  import led_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int CNT_W    = 4
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   count,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     LED
);

  localparam int TICK_W = tick_width(TICK_DIV);
  localparam int IDX_W  = (N_REQ < 2) ? 1 : $clog2(N_REQ);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  state_t            state;
  logic [TICK_W-1:0] tick;
  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  ptr;

  logic [N_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic [CNT_W-1:0]  sel_count;
  logic              tick_end;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .index (arb_idx)
  );

  // Blink count of the requester that would win this cycle; only read at the grant edge.
  assign sel_count = count[arb_idx*CNT_W +: CNT_W];
  assign tick_end  = (tick == TICK_LAST);

  // Owner FSM: grant, ON/OFF half-periods, trailing gap, then the done pulse.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      LED       <= 1'b0;
      tick      <= '0;
      remaining <= '0;
      ptr       <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          // A pending done blocks the grant, forcing an idle cycle between owners.
          if ((req != '0) && (done == '0)) begin
            gnt       <= arb_grant;
            remaining <= sel_count;
            tick      <= '0;
            busy      <= 1'b1;
            ptr       <= (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
            if (sel_count != '0) begin
              LED   <= 1'b1;
              state <= ON;
            end else begin
              LED   <= 1'b0;
              state <= GAP;
            end
          end
        end

        ON: begin
          if (tick_end) begin
            tick  <= '0;
            LED   <= 1'b0;
            state <= OFF;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        OFF: begin
          if (tick_end) begin
            tick      <= '0;
            remaining <= remaining - 1'b1;
            if (remaining == CNT_ONE) begin
              state <= GAP;
            end else begin
              LED   <= 1'b1;
              state <= ON;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end

        GAP: begin
          LED <= 1'b0;
          if (tick_end) begin
            done  <= gnt;
            gnt   <= '0;
            tick  <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tick <= tick + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_arbiter.sv
// Directed bench for led_blink_arbiter with TICK_DIV=4, N_REQ=4, CNT_W=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_blink_arbiter;

  localparam int N_REQ    = 4;
  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic [3:0]  req      = '0;
  logic [15:0] count    = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic        LED;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  led_blink_arbiter #(
    .N_REQ    (N_REQ),
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .req      (req),
    .count    (count),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .LED      (LED)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Edge counter used to timestamp grants and done pulses.
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_gnt(input string tag, input int limit, output int at);
    int i;
    i = 0;
    while (gnt == '0 && i < limit) begin
      step(1);
      i++;
    end
    check({tag, " grant seen"}, {31'b0, gnt != '0}, 32'd1);
    at = cyc;
  endtask

  task automatic wait_done(input string tag, input int limit, output int at);
    int i;
    i = 0;
    while (done == '0 && i < limit) begin
      step(1);
      i++;
    end
    check({tag, " done seen"}, {31'b0, done != '0}, 32'd1);
    at = cyc;
  endtask

  initial begin
    int t_g, t_d, prev_g, bad, dcnt, blinks;
    logic [19:0] pat;
    logic led_seen, prev_led;

    // Reset state.
    reset = 1'b0;
    #2;
    check("rst gnt", gnt, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst led", LED, 0);
    step(2);
    reset = 1'b1;
    step(1);

    // Single burst, count0=2: on4 off4 on4 off4 gap4, done 20 cycles after grant.
    req   = 4'b0001;
    count = 16'h0002;
    step(1);
    check("burst gnt", gnt, 4'b0001);
    check("burst busy", busy, 1);
    pat  = '0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      pat[k] = LED;
      if (done != '0) dcnt++;
      step(1);
    end
    check("burst led pattern", pat, 20'b0000_0000_1111_0000_1111);
    check("burst early done", dcnt, 0);
    check("burst done", done, 4'b0001);
    check("burst gnt cleared", gnt, 0);
    check("burst busy cleared", busy, 0);
    req = 4'b0000;
    step(1);
    check("burst done one cycle", done, 0);

    // Round robin from pointer 0: order 0,1,2,3,0; 12-cycle services, grants 14 apart
    // (12 service cycles, the done cycle, one idle cycle).
    reset = 1'b0;
    step(1);
    reset  = 1'b1;
    count  = 16'h1111;
    req    = 4'b1111;
    prev_g = 0;
    for (int s = 0; s < 5; s++) begin
      wait_gnt("rr", 40, t_g);
      check("rr order", gnt, 32'(1) << (s % 4));
      if (s > 0) check("rr spacing", t_g - prev_g, 14);
      prev_g = t_g;
      wait_done("rr", 40, t_d);
      check("rr service len", t_d - t_g, 12);
    end
    req = 4'b0000;
    step(2);

    // Zero count on lane 2: no LED activity, done 4 cycles after grant.
    req   = 4'b0100;
    count = 16'h0000;
    wait_gnt("zero", 10, t_g);
    check("zero gnt", gnt, 4'b0100);
    led_seen = 1'b0;
    for (int i = 0; i < 20 && done == '0; i++) begin
      led_seen = led_seen | LED;
      step(1);
    end
    led_seen = led_seen | LED;
    t_d = cyc;
    check("zero led", led_seen, 0);
    check("zero done", done, 4'b0100);
    check("zero service len", t_d - t_g, 4);
    req = 4'b0000;
    step(1);

    // Late request on lane 1 waits; lane 0 drops req mid-burst but still finishes.
    req   = 4'b0001;
    count = 16'h0002;
    wait_gnt("late", 10, t_g);
    check("late gnt", gnt, 4'b0001);
    pat = '0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      pat[k] = LED;
      if (gnt != 4'b0001) bad++;
      if (k == 2) req = 4'b0011;
      if (k == 6) req = 4'b0010;
      step(1);
    end
    check("late led pattern", pat, 20'b0000_0000_1111_0000_1111);
    check("late gnt held", bad, 0);
    check("late done", done, 4'b0001);
    step(1);
    check("late no grant in done cycle", gnt, 0);
    step(1);
    check("late next gnt", gnt, 4'b0010);
    wait_done("late1", 20, t_d);
    check("late1 done", done, 4'b0010);
    req = 4'b0000;
    step(1);

    // Async reset during ON, then pointer restarts at 0 (lane 1 beats lane 3).
    req   = 4'b0010;
    count = 16'h0020;
    wait_gnt("arst", 10, t_g);
    check("arst gnt", gnt, 4'b0010);
    step(1);
    check("arst led on", LED, 1);
    reset = 1'b0;
    #2;
    check("arst led", LED, 0);
    check("arst gnt off", gnt, 0);
    check("arst busy", busy, 0);
    step(1);
    req   = 4'b1010;
    count = 16'h1010;
    reset = 1'b1;
    wait_gnt("arst2", 10, t_g);
    check("arst ptr restart", gnt, 4'b0010);
    req = 4'b1000;
    wait_done("arst2", 20, t_d);
    wait_gnt("arst3", 10, t_g);
    check("arst lane3 gnt", gnt, 4'b1000);
    wait_done("arst3", 20, t_d);
    req = 4'b0000;
    step(1);

    // Count sampled only at grant: 3 blinks even though count0 drops to 1.
    req   = 4'b0001;
    count = 16'h0003;
    wait_gnt("samp", 10, t_g);
    check("samp gnt", gnt, 4'b0001);
    blinks   = 0;
    prev_led = 1'b0;
    for (int i = 0; i < 100 && done == '0; i++) begin
      if (LED && !prev_led) blinks++;
      prev_led = LED;
      if (i == 1) count = 16'h0001;
      step(1);
    end
    t_d = cyc;
    check("samp blinks", blinks, 3);
    check("samp done", done, 4'b0001);
    check("samp service len", t_d - t_g, 28);
    req = 4'b0000;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
